key_angle_ctrl: RTL and testbench

//  Turns raw inc/dec push-button levels into a rotation offset for the rotation engine.

---
 rtl/angle_pkg.sv | 12 +
 rtl/key_repeat.sv | 55 +++++
 rtl/key_angle_ctrl.sv | 97 +++++++++
 tb/tb_key_angle_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/angle_pkg.sv
// Shared types and defaults for the key-driven rotation offset block.
package angle_pkg;
  localparam int          W_DEF         = 16;
  localparam int unsigned ANGLE_MOD_DEF = 1440;

  typedef enum logic [1:0] {
    IDLE,
    DEB,
    HOLD,
    REPEAT
  } key_state_e;
endpackage

// File: rtl/key_repeat.sv
// Per-key debounce / hold / auto-repeat FSM; emits a one-cycle registered step_p.
module key_repeat
  import angle_pkg::*;
#(
  parameter int unsigned DEB_CYC    = 50000,
  parameter int unsigned HOLD_CYC   = 25000000,
  parameter int unsigned REPEAT_CYC = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic step_p
);

  key_state_e  state;
  logic [31:0] cnt;
  logic [31:0] term;

  always_comb begin
    term = REPEAT_CYC - 32'd1;
    case (state)
      DEB:     term = DEB_CYC - 32'd1;
      HOLD:    term = HOLD_CYC - 32'd1;
      default: term = REPEAT_CYC - 32'd1;
    endcase
  end

  // Release is taken immediately; any re-press has to pass DEB again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      step_p <= 1'b0;
    end else begin
      step_p <= 1'b0;
      if (state == IDLE) begin
        if (key) begin
          state <= DEB;
          cnt   <= '0;
        end
      end else if (!key) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (cnt == term) begin
        step_p <= 1'b1;
        cnt    <= '0;
        if (state == DEB) state <= HOLD;
        else              state <= REPEAT;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/key_angle_ctrl.sv
// Key-driven modular rotation offset plus 2-stage angle_adj = (angle_in + offset) mod ANGLE_MOD.
module key_angle_ctrl
  import angle_pkg::*;
#(
  parameter int          W           = W_DEF,
  parameter int unsigned ANGLE_MOD   = ANGLE_MOD_DEF,
  parameter int unsigned STEP_FINE   = 1,
  parameter int unsigned STEP_COARSE = 20,
  parameter int unsigned DEB_CYC     = 50000,
  parameter int unsigned HOLD_CYC    = 25000000,
  parameter int unsigned REPEAT_CYC  = 2500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         coarse,
  input  logic         zero,
  input  logic [W-1:0] angle_in,
  input  logic         angle_in_vld,
  output logic [W-1:0] offset,
  output logic [W-1:0] angle_adj,
  output logic         angle_vld,
  output logic         angle_err
);

  localparam int         NUM_KEYS = 2;
  localparam int         STAGES   = 2;
  localparam logic [W:0] MOD      = (W+1)'(ANGLE_MOD);
  localparam logic [W:0] STEP_F   = (W+1)'(STEP_FINE);
  localparam logic [W:0] STEP_C   = (W+1)'(STEP_COARSE);

  // Bit 0 = inc, bit 1 = dec.
  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] step_p;

  assign key_lvl = {dec, inc};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_repeat #(
      .DEB_CYC    (DEB_CYC),
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC)
    ) u_key (
      .clk    (clk),
      .rst    (rst),
      .key    (key_lvl[k]),
      .step_p (step_p[k])
    );
  end

  logic [W:0] step, off_ext, inc_s, dec_s, off_nxt;

  // zero clears on any cycle it is seen and beats a coincident step.
  always_comb begin
    step    = coarse ? STEP_C : STEP_F;
    off_ext = {1'b0, offset};
    inc_s   = off_ext + step;
    if (inc_s >= MOD) inc_s = inc_s - MOD;
    dec_s   = (off_ext < step) ? off_ext + MOD - step : off_ext - step;
    off_nxt = off_ext;
    if (zero)                        off_nxt = '0;
    else if (step_p == 2'b01)        off_nxt = inc_s;
    else if (step_p == 2'b10)        off_nxt = dec_s;
  end

  always_ff @(posedge clk) begin
    if (rst) offset <= '0;
    else     offset <= off_nxt[W-1:0];
  end

  logic [W:0]        sum, adj_w;
  logic              err1;
  logic [STAGES:1]   vld_pipe;

  // Single conditional subtract is exact only while angle_in < ANGLE_MOD.
  assign adj_w = (sum >= MOD) ? sum - MOD : sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      err1      <= 1'b0;
      angle_adj <= '0;
      angle_err <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      sum       <= {1'b0, angle_in} + off_ext;
      err1      <= ({1'b0, angle_in} >= MOD);
      angle_adj <= adj_w[W-1:0];
      angle_err <= err1;
      vld_pipe  <= {vld_pipe[STAGES-1:1], angle_in_vld};
    end
  end

  assign angle_vld = vld_pipe[STAGES];

endmodule

// File: tb/tb_key_angle_ctrl.sv
// Scoreboard bench for key_angle_ctrl with short debounce/hold/repeat counts.
module tb_key_angle_ctrl;

  localparam int MOD = 1440;

  logic        clk = 1'b0;
  logic        rst, inc, dec, coarse, zero, angle_in_vld;
  logic [15:0] angle_in;
  logic [15:0] offset, angle_adj;
  logic        angle_vld, angle_err;

  key_angle_ctrl #(
    .W(16), .ANGLE_MOD(1440), .STEP_FINE(1), .STEP_COARSE(4),
    .DEB_CYC(4), .HOLD_CYC(20), .REPEAT_CYC(5)
  ) u_dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .coarse(coarse), .zero(zero),
    .angle_in(angle_in), .angle_in_vld(angle_in_vld), .offset(offset),
    .angle_adj(angle_adj), .angle_vld(angle_vld), .angle_err(angle_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int adj;
    int err;
    bit chk_adj;
    int cyc;
  } ang_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   exp_off = 0;
  int   prev_off = 0;
  bit   mon_en  = 1'b0;
  int   off_q[$];
  int   chg_q[$];
  ang_t ang_q[$];

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Offset and angle scoreboards, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(offset) != prev_off) begin
        chg_q.push_back(cyc);
        if (off_q.size() == 0) chk("unexp_offset_change", int'(offset), prev_off);
        else                   chk("offset", int'(offset), off_q.pop_front());
        chk("offset_range", int'(offset < 16'(MOD)), 1);
        prev_off = int'(offset);
      end
      if (angle_vld) begin
        if (ang_q.size() == 0) chk("unexp_angle_vld", 1, 0);
        else begin
          ang_t e;
          e = ang_q.pop_front();
          chk("angle_latency", cyc, e.cyc);
          if (e.chk_adj) chk("angle_adj", int'(angle_adj), e.adj);
          chk("angle_err", int'(angle_err), e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_off(input int v);
    off_q.push_back(v);
    exp_off = v;
  endtask

  task automatic press(input bit is_dec, input int n);
    if (is_dec) dec = 1'b1; else inc = 1'b1;
    repeat (n) tick();
    inc = 1'b0;
    dec = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_zero();
    push_off(0);
    zero = 1'b1;
    tick();
    zero = 1'b0;
    repeat (2) tick();
  endtask

  task automatic drive_angle(input int a);
    ang_t e;
    int   s;
    s         = a + exp_off;
    e.err     = (a >= MOD) ? 1 : 0;
    e.adj     = (s >= MOD) ? s - MOD : s;
    e.chk_adj = (a < MOD);
    e.cyc     = cyc + 2;
    ang_q.push_back(e);
    angle_in     = 16'(a);
    angle_in_vld = 1'b1;
    tick();
    angle_in_vld = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1; inc = 1'b1; dec = 1'b0; coarse = 1'b0; zero = 1'b0;
    angle_in = '0; angle_in_vld = 1'b0;

    // Reset held with inc pressed.
    repeat (2) tick();
    chk("rst_offset", int'(offset), 0);
    chk("rst_angle_adj", int'(angle_adj), 0);
    chk("rst_angle_vld", int'(angle_vld), 0);
    chk("rst_angle_err", int'(angle_err), 0);
    rst = 1'b0;
    prev_off = 0;
    mon_en = 1'b1;
    repeat (4) tick();
    chk("no_early_step", int'(offset), 0);
    tick();
    inc = 1'b0;
    push_off(1);
    repeat (4) tick();

    // Short press is swallowed; a 10-cycle press gives exactly one step.
    inc = 1'b1;
    repeat (3) tick();
    inc = 1'b0;
    repeat (10) tick();
    chk("short_press", int'(offset), 1);
    push_off(2);
    press(1'b0, 10);

    // Wrap down from 0, then angle through the pipeline.
    pulse_zero();
    push_off(1439);
    press(1'b1, 6);
    drive_angle(5);
    repeat (4) tick();

    // Debounce, hold and three repeats; check step spacing.
    pulse_zero();
    chg_q.delete();
    c0 = cyc;
    for (int v = 1; v <= 5; v++) push_off(v);
    inc = 1'b1;
    repeat (40) tick();
    inc = 1'b0;
    repeat (3) tick();
    chk("repeat_count", chg_q.size(), 5);
    if (chg_q.size() == 5) begin
      chk("first_step_time", chg_q[0] - c0, 6);
      chk("hold_spacing", chg_q[1] - chg_q[0], 20);
      for (int i = 2; i < 5; i++) chk("repeat_spacing", chg_q[i] - chg_q[i-1], 5);
    end

    // Coarse wrap up and down, simultaneous keys.
    pulse_zero();
    push_off(1439);
    press(1'b1, 6);
    push_off(1438);
    press(1'b1, 6);
    coarse = 1'b1;
    push_off(2);
    press(1'b0, 6);
    push_off(1438);
    press(1'b1, 6);
    inc = 1'b1;
    dec = 1'b1;
    repeat (6) tick();
    inc = 1'b0;
    dec = 1'b0;
    repeat (3) tick();
    chk("both_keys", int'(offset), 1438);
    coarse = 1'b0;

    // zero while repeating: the next repeat continues from 0.
    pulse_zero();
    push_off(1); push_off(2); push_off(0); push_off(1);
    inc = 1'b1;
    repeat (26) tick();
    zero = 1'b1;
    tick();
    zero = 1'b0;
    repeat (3) tick();
    inc = 1'b0;
    repeat (3) tick();

    // Reset during HOLD: FSM must restart from debounce.
    push_off(2);
    inc = 1'b1;
    repeat (8) tick();
    push_off(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_off(1);
    repeat (10) tick();
    inc = 1'b0;
    repeat (3) tick();
    chk("post_rst_offset", int'(offset), 1);

    // Back-to-back angles: wrap boundary, zero, mid-range, out of range.
    drive_angle(1439);
    drive_angle(0);
    drive_angle(700);
    drive_angle(1500);
    repeat (5) tick();

    chk("offset_q_drain", off_q.size(), 0);
    chk("angle_q_drain", ang_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
